// File: rtl/pc_fetch_ctrl.sv
// Fetch PC owner for the 5-stage pipeline: selects the next PC, drives the
// instruction memory request and the IF/ID valid/flush strobes.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exc,
    input  logic        halt,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus_out,
    output logic        if_valid,
    output logic        flush,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_v_q, pend_v_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic        fire_s;
    logic        redirect_s;
    logic        run_s;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_BOOT;
            pc_q          <= RESET_PC;
            pend_v_q      <= 1'b0;
            pend_target_q <= 32'h0000_0000;
            fetch_cnt_q   <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_v_q      <= pend_v_d;
            pend_target_q <= pend_target_d;
            fetch_cnt_q   <= fetch_cnt_d;
        end
    end

    // Next-state and next-PC selection in strict priority order
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_v_d      = pend_v_q;
        pend_target_d = pend_target_q;
        fetch_cnt_d   = if_valid ? (fetch_cnt_q + 32'd1) : fetch_cnt_q;
        if (exc) begin
            pc_d     = EXC_VECTOR;
            pend_v_d = 1'b0;
            state_d  = S_RUN;
        end else begin
            case (state_q)
                S_BOOT: state_d = S_RUN;
                S_RUN: begin
                    if (!stall && branch_taken) begin
                        pc_d     = branch_target;
                        pend_v_d = 1'b0;
                    end else if (!stall && jump) begin
                        pc_d     = jump_target;
                        pend_v_d = 1'b0;
                    end else if (!stall && pend_v_q) begin
                        pc_d     = pend_target_q;
                        pend_v_d = 1'b0;
                    end else if (stall && (branch_taken || jump)) begin
                        // Late redirect during a stall: park it, newest wins
                        pend_v_d      = 1'b1;
                        pend_target_d = branch_taken ? branch_target : jump_target;
                    end else if (!stall && halt) begin
                        state_d  = S_HALT;
                        pend_v_d = 1'b0;
                    end else if (fire_s) begin
                        pc_d = pc_q + 32'd1;
                    end else begin
                        pc_d = pc_q;
                    end
                end
                S_HALT: state_d = S_HALT;
                default: state_d = S_BOOT;
            endcase
        end
    end

    // Memory request and IF/ID strobes; all quiet while reset is asserted
    always_comb begin
        run_s      = (state_q == S_RUN);
        imem_req   = !rst && run_s && !stall;
        fire_s     = imem_req && imem_ready;
        redirect_s = !rst && (exc || (run_s && !stall && (branch_taken || jump || pend_v_q)));
        if_valid   = fire_s && !redirect_s;
        flush      = redirect_s;
    end

    assign pc_out      = pc_q;
    assign imem_addr   = pc_q;
    assign pc_plus_out = pc_q + 32'd1;
    assign fetch_cnt   = fetch_cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed vector table for the documented corner
// cases followed by randomized traffic checked against a rule-level model.
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst, stall, branch_taken, jump, exc, halt, imem_ready;
    logic [31:0] branch_target, jump_target;
    logic        imem_req, if_valid, flush;
    logic [31:0] imem_addr, pc_out, pc_plus_out, fetch_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl dut (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .exc(exc), .halt(halt), .imem_ready(imem_ready),
        .imem_req(imem_req), .imem_addr(imem_addr), .pc_out(pc_out),
        .pc_plus_out(pc_plus_out), .if_valid(if_valid), .flush(flush),
        .fetch_cnt(fetch_cnt)
    );

    typedef struct {
        logic        rst, stall, bt;
        logic [31:0] btgt;
        logic        jmp;
        logic [31:0] jtgt;
        logic        exc, halt, rdy;
        logic        e_req, e_val, e_fl;
        logic [31:0] e_pc, e_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, s, b, input logic [31:0] bt_t, input logic j,
                       input logic [31:0] j_t, input logic e, h, rd,
                       input logic eq, ev, ef, input logic [31:0] epc, ecnt);
        vec_t v;
        v.rst = r; v.stall = s; v.bt = b; v.btgt = bt_t; v.jmp = j; v.jtgt = j_t;
        v.exc = e; v.halt = h; v.rdy = rd; v.e_req = eq; v.e_val = ev; v.e_fl = ef;
        v.e_pc = epc; v.e_cnt = ecnt;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, s, b, input logic [31:0] bt_t, input logic j,
                         input logic [31:0] j_t, input logic e, h, rd);
        rst = r; stall = s; branch_taken = b; branch_target = bt_t;
        jump = j; jump_target = j_t; exc = e; halt = h; imem_ready = rd;
    endtask

    // Rule-level reference: mode 0=boot, 1=run, 2=halted
    int          m_mode;
    logic [31:0] m_pc, m_pt, m_cnt;
    logic        m_pv;

    initial begin
        logic        x_req, x_fire, x_redir, x_val;
        logic        r, s, b, j, e, h, rd;
        logic [31:0] bt_t, j_t;

        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);

        //   rst  stl  bt   btgt           jmp  jtgt           exc  hlt  rdy  req  val  fl   pc             cnt
        add(1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        32'd0);
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        32'd0);
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,32'h0,        32'd0);
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,32'h1,        32'd1);
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,32'h2,        32'd2);
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,32'h3,        32'd3);
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,32'h4,        32'd4);
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,32'h5,        32'd5);
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,32'h5,        32'd5);
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,32'h5,        32'd5);
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,32'h6,        32'd6);
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,32'h7,        32'd7);
        add(1'b0,1'b1,1'b1,32'h40,       1'b0,32'h0,        1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h8,        32'd8);
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,32'h8,        32'd8);
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,32'h40,       32'd8);
        add(1'b0,1'b0,1'b0,32'h0,        1'b1,32'h10,       1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,32'h41,       32'd9);
        add(1'b0,1'b1,1'b1,32'h40,       1'b0,32'h0,        1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,32'h10,       32'd9);
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,32'h20,       32'd9);
        add(1'b0,1'b0,1'b0,32'h0,        1'b1,32'hFFFF_FFFF,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,32'h21,       32'd10);
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,32'hFFFF_FFFF,32'd10);
        add(1'b0,1'b0,1'b0,32'h0,        1'b1,32'h30,       1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,32'h0,        32'd11);
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,32'h30,       32'd11);
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h30,       32'd11);
        add(1'b0,1'b0,1'b1,32'h44,       1'b0,32'h0,        1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h30,       32'd11);
        add(1'b0,1'b1,1'b0,32'h0,        1'b1,32'h48,       1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h30,       32'd11);
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,32'h30,       32'd11);
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h30,       32'd11);
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,32'h30,       32'd11);
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,32'h20,       32'd11);
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,32'h21,       32'd12);
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h21,       32'd12);
        add(1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,32'h21,       32'd12);
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        32'd0);
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,32'h0,        32'd0);
        add(1'b0,1'b0,1'b1,32'h50,       1'b1,32'h60,       1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,32'h1,        32'd1);
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,32'h50,       32'd1);
        add(1'b0,1'b1,1'b0,32'h0,        1'b1,32'h70,       1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h51,       32'd2);
        add(1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h51,       32'd2);
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        32'd0);
        add(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,32'h0,        32'd0);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].stall, tbl[i].bt, tbl[i].btgt, tbl[i].jmp,
                  tbl[i].jtgt, tbl[i].exc, tbl[i].halt, tbl[i].rdy);
            #1;
            chk($sformatf("vec%0d.imem_req", i), {31'd0, imem_req}, {31'd0, tbl[i].e_req});
            chk($sformatf("vec%0d.if_valid", i), {31'd0, if_valid}, {31'd0, tbl[i].e_val});
            chk($sformatf("vec%0d.flush", i),    {31'd0, flush},    {31'd0, tbl[i].e_fl});
            chk($sformatf("vec%0d.pc_out", i),   pc_out,   tbl[i].e_pc);
            chk($sformatf("vec%0d.imem_addr", i), imem_addr, tbl[i].e_pc);
            chk($sformatf("vec%0d.pc_plus", i),  pc_plus_out, tbl[i].e_pc + 32'd1);
            chk($sformatf("vec%0d.fetch_cnt", i), fetch_cnt, tbl[i].e_cnt);
            @(posedge clk);
            @(negedge clk);
        end

        // Randomized traffic against the reference model
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        m_mode = 0; m_pc = 32'h0; m_pv = 1'b0; m_pt = 32'h0; m_cnt = 32'h0;

        for (int n = 0; n < 3000; n++) begin
            r    = ($urandom_range(0, 99) == 0);
            s    = ($urandom_range(0, 3) == 0);
            b    = ($urandom_range(0, 7) == 0);
            j    = ($urandom_range(0, 7) == 0);
            e    = ($urandom_range(0, 39) == 0);
            h    = ($urandom_range(0, 29) == 0);
            rd   = ($urandom_range(0, 3) != 0);
            bt_t = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 2))) : $urandom;
            j_t  = $urandom;
            drive(r, s, b, bt_t, j, j_t, e, h, rd);
            #1;

            x_req   = !r && (m_mode == 1) && !s;
            x_fire  = x_req && rd;
            x_redir = !r && (e || ((m_mode == 1) && !s && (b || j || m_pv)));
            x_val   = x_fire && !x_redir;
            chk("rnd.imem_req", {31'd0, imem_req}, {31'd0, x_req});
            chk("rnd.if_valid", {31'd0, if_valid}, {31'd0, x_val});
            chk("rnd.flush",    {31'd0, flush},    {31'd0, x_redir});
            chk("rnd.pc_out",   pc_out,   m_pc);
            chk("rnd.imem_addr", imem_addr, m_pc);
            chk("rnd.pc_plus",  pc_plus_out, m_pc + 32'd1);
            chk("rnd.fetch_cnt", fetch_cnt, m_cnt);

            if (r) begin
                m_mode = 0; m_pc = 32'h0; m_pv = 1'b0; m_pt = 32'h0; m_cnt = 32'h0;
            end else begin
                if (x_val) m_cnt = m_cnt + 32'd1;
                if (e) begin
                    m_pc = 32'h20; m_pv = 1'b0; m_mode = 1;
                end else if (m_mode == 0) begin
                    m_mode = 1;
                end else if (m_mode == 1) begin
                    if (!s && (b || j || m_pv)) begin
                        m_pc = b ? bt_t : (j ? j_t : m_pt);
                        m_pv = 1'b0;
                    end else if (s && (b || j)) begin
                        m_pv = 1'b1;
                        m_pt = b ? bt_t : j_t;
                    end else if (!s && h) begin
                        m_mode = 2; m_pv = 1'b0;
                    end else if (x_fire) begin
                        m_pc = m_pc + 32'd1;
                    end
                end
            end
            @(posedge clk);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Owns the fetch PC of the 5-stage pipeline and drives the PC incrementer, instruction memory request and IF/ID valid/flush.
- Selects the next PC each cycle from: sequential (PC+1, word addressed), branch, jump or exception vector.
- Honours hazard stalls and holds late redirects in a one-entry pending latch.
- Sits between the hazard/branch units in ID and the IF stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word address).
- EXC_VECTOR, 32'h0000_0020, exception handler entry (word address).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit: hold PC and IF/ID this cycle.
- branch_taken  in  1  ID-resolved taken branch.
- branch_target  in  32  branch destination.
- jump  in  1  ID jump.
- jump_target  in  32  jump destination.
- exc  in  1  exception redirect; highest priority.
- halt  in  1  stop fetching (break/syscall halt).
- imem_ready  in  1  instruction memory accepts/returns this cycle.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address (= pc_out).
- pc_out  out  32  current PC register.
- pc_plus_out  out  32  pc_out+1, to IF/ID for link.
- if_valid  out  1  fetched instruction enters IF/ID this edge.
- flush  out  1  squash IF/ID (redirect applied).
- fetch_cnt  out  32  count of valid fetches.

Behaviour:
- Reset (sync, rst=1 at edge): pc=RESET_PC, state=S_BOOT, pend_v=0, pend_target=0, fetch_cnt=0. While rst is high: imem_req=0, if_valid=0, flush=0. rst overrides every other input, including mid-stall or pending.
- States:
  - S_BOOT: one cycle, no request; goes to S_RUN unless exc.
  - S_RUN: normal fetch.
  - S_HALT: no request; left only via exc (to S_RUN) or rst.
- Combinational signals:
  - imem_req = (state==S_RUN) & ~stall. The memory samples addr only when req&ready; dropping req before ready is legal.
  - fire = imem_req & imem_ready.
  - redirect = exc | (~stall & (branch_taken | jump | pend_v)) in S_RUN; in S_BOOT/S_HALT redirect = exc only.
  - if_valid = fire & ~redirect.
  - flush = redirect.
  - pc_plus_out = pc+1 mod 2^32 (32'hFFFF_FFFF -> 0).
- Next-PC priority, evaluated at each edge:
  1. exc: pc=EXC_VECTOR, pend_v=0, state=S_RUN (from any state). Ignores stall, halt, branch and jump.
  2. ~stall & branch_taken: pc=branch_target, pend_v=0.
  3. ~stall & jump: pc=jump_target, pend_v=0.
  4. ~stall & pend_v: pc=pend_target, pend_v=0.
  5. stall & (branch_taken|jump), S_RUN: pc holds; pend_v=1; pend_target=branch_target if branch_taken, else jump_target. A newer capture overwrites an older one.
  6. ~stall & halt, S_RUN: state=S_HALT, pc holds, pend_v=0.
  7. fire: pc=pc+1 (wraps).
  8. otherwise: pc holds (stall, or waiting on imem_ready).
- Branch and jump together: branch wins. New branch/jump inputs override a pending entry on the same unstalled cycle.
- fetch_cnt increments by 1 on every cycle with if_valid=1; wraps at 2^32.
- Latency: a redirect presented in cycle N gives imem_addr = target in cycle N+1. The wrong-path fetch in cycle N is dropped (if_valid=0).
- Inputs in S_BOOT/S_HALT other than exc and rst are ignored (no pending capture).

Test Plan:
- Reset then run, imem_ready=1 constant: cycle after BOOT imem_addr=0, then 1, 2, 3; if_valid=1 each cycle; fetch_cnt=3 after three fetches.
- imem_ready=0 for 2 cycles at pc=5: imem_req=1, pc stays 5, if_valid=0; ready=1 -> if_valid=1, pc=6.
- stall=1 with branch_taken=1, target=0x40, at pc=8: imem_req=0, pc stays 8, pend_v=1. Release stall (branch input low): flush=1, if_valid=0, next pc=0x40.
- exc=1 with branch_taken=1 (target 0x40) and stall=1 at pc=0x10: next pc=0x20, pend_v cleared, flush=1. Next cycle fetch addr 0x20.
- Wrap: pc=32'hFFFF_FFFF, fire -> pc_plus_out=0 and next pc=0.
- halt=1 at pc=0x30: S_HALT, imem_req=0 for 5 cycles, pc=0x30. exc -> pc=0x20, fetch resumes. Separately, rst mid-halt -> pc=0, S_BOOT.
